// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial frame link (transmitter and receiver sides).
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        GAP
    } tx_state_e;

    localparam logic [3:0] SYNC_1010 = 4'b1010;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Payload shift register: parallel load, shift left so the MSB is always the next bit to send.
module tx_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              msb
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
            data_d = data_q << 1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign msb = data_q[DATA_W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync word, MSB-first payload, then a zero gap, one bit per clock.
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_1010),
    parameter int                GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din_data,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              dout_last,
    output logic              busy
);

    localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;
    logic             busy_q, busy_d;
    logic             din_ready_q, din_ready_d;
    logic             xfer;
    logic             sync_bit;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_msb;

    tx_shift_reg #(
        .DATA_W(DATA_W)
    ) u_shift_reg (
        .clk      (clk),
        .resetn   (resetn),
        .load     (sr_load),
        .shift    (sr_shift),
        .load_data(din_data),
        .msb      (sr_msb)
    );

    // Outputs are computed for the state being entered, so every output is a flop.
    always_comb begin
        xfer    = din_valid && din_ready_q;
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer) state_d = SYNC;
            end
            SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d = '0;
                    if (GAP_CYCLES > 0) state_d = GAP;
                    else                state_d = xfer ? SYNC : IDLE;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = xfer ? SYNC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        sync_bit = 1'b0;
        for (int i = 0; i < SYNC_W; i++) begin
            if (cnt_d == CNT_W'(i)) sync_bit = SYNC_PATTERN[SYNC_W-1-i];
        end

        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
        din_ready_d  = 1'b0;
        unique case (state_d)
            IDLE: din_ready_d = 1'b1;
            SYNC: begin
                dout_d       = sync_bit;
                dout_valid_d = 1'b1;
            end
            DATA: begin
                dout_d       = sr_msb;
                dout_valid_d = 1'b1;
                dout_last_d  = (cnt_d == DATA_LAST);
                din_ready_d  = (GAP_CYCLES == 0) && (cnt_d == DATA_LAST);
            end
            GAP:  din_ready_d = (cnt_d == GAP_LAST);
            default: din_ready_d = 1'b0;
        endcase

        busy_d   = (state_d != IDLE);
        sr_load  = xfer;
        sr_shift = (state_d == DATA);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            din_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
            din_ready_q  <= din_ready_d;
        end
    end

    assign din_ready  = din_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = busy_q;

endmodule
